// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the parametrised sync FIFO.
// Imported by the interface, the RAM and the FIFO control block.
package fifo_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_AF_LEVEL = 6;
  localparam int DEF_AE_LEVEL = 2;

  // Address width that never collapses to zero bits.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_sync_param_if.sv
// FIFO bus: write data/strobes in, registered read data and status out.
// master = producer/consumer side, slave = the FIFO itself.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output in, we, re,
    input  out, out_valid,
    input  full, empty,
    input  almost_full, almost_empty,
    input  count,
    input  overflow, underflow
  );

  modport slave (
    input  in, we, re,
    output out, out_valid,
    output full, empty,
    output almost_full, almost_empty,
    output count,
    output overflow, underflow
  );

endinterface

// File: rtl/fifo_sync_param_ram.sv
// Storage for the FIFO: one write port, one synchronous read port.
// No reset; contents are only meaningful where control says so.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = clog2_safe(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: count-based full/empty, thresholds,
// 1-cycle registered read with valid strobe, sticky over/underflow.
// Ports: clk, rst (sync, active-high), bus (fifo_sync_param_if.slave).
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL,
  parameter int AE_LEVEL = DEF_AE_LEVEL
) (
  input logic               clk,
  input logic               rst,
  fifo_sync_param_if.slave  bus
);

  localparam int PW = clog2_safe(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL out of range 1..DEPTH");
  end
  if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count_q;
  logic             ovf_q;
  logic             unf_q;
  logic             vld_q;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] rdata;
  logic             wr_ok;
  logic             rd_ok;
  fifo_status_t     st;

  always_comb begin
    st              = '0;
    st.full         = (count_q == CW'(DEPTH));
    st.empty        = (count_q == '0);
    st.almost_full  = (count_q >= CW'(AF_LEVEL));
    st.almost_empty = (count_q <= CW'(AE_LEVEL));
    st.overflow     = ovf_q;
    st.underflow    = unf_q;
  end

  // Reset blocks both ports, including the RAM write.
  assign wr_ok = bus.we & ~st.full & ~rst;
  assign rd_ok = bus.re & ~st.empty & ~rst;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (head),
    .wdata (bus.in),
    .re    (rd_ok),
    .raddr (tail),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      vld_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      if (wr_ok) head <= head + 1'b1;
      if (rd_ok) tail <= tail + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ovf_q <= ovf_q | (bus.we & st.full);
      unf_q <= unf_q | (bus.re & st.empty);
      vld_q <= rd_ok;
      // Capture the word just presented so out holds it afterwards.
      if (vld_q) hold_q <= rdata;
    end
  end

  // RAM output is live only in the valid cycle; hold_q covers the
  // rest, and gives out=0 after reset since the RAM is not reset.
  assign bus.out          = vld_q ? rdata : hold_q;
  assign bus.out_valid    = vld_q;
  assign bus.full         = st.full;
  assign bus.empty        = st.empty;
  assign bus.almost_full  = st.almost_full;
  assign bus.almost_empty = st.almost_empty;
  assign bus.count        = count_q;
  assign bus.overflow     = st.overflow;
  assign bus.underflow    = st.underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (WIDTH=8, DEPTH=8, AF=6, AE=2).
// Directed stimulus pushes expected words; a monitor pops on out_valid.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  fifo_sync_param_if #(.WIDTH(8), .DEPTH(8)) bus ();

  fifo_sync_param #(
    .WIDTH    (8),
    .DEPTH    (8),
    .AF_LEVEL (6),
    .AE_LEVEL (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    bus.we = w;
    bus.re = r;
    bus.in = d;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    bus.re = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got %0h want none", bus.out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out !== e) begin
          fails++;
          $display("FAIL sb_data: got %0h want %0h", bus.out, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;
    bus.we = 1'b0;
    bus.re = 1'b0;
    bus.in = '0;

    // 1: reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cyc(0, 0, 8'h00);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_aempty", int'(bus.almost_empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_afull", int'(bus.almost_full), 0);
    check("rst_count", int'(bus.count), 0);
    check("rst_out", int'(bus.out), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_ovf", int'(bus.overflow), 0);
    check("rst_unf", int'(bus.underflow), 0);

    // 2: fill 0x11..0x88, then drain in order
    for (int i = 0; i < 8; i++) begin
      v = 8'(8'h11 * (i + 1));
      cyc(1, 0, v);
      check("t2_count", int'(bus.count), i + 1);
      check("t2_afull", int'(bus.almost_full), (i + 1 >= 6) ? 1 : 0);
      check("t2_aempty", int'(bus.almost_empty), (i + 1 <= 2) ? 1 : 0);
      check("t2_full", int'(bus.full), (i == 7) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      v = 8'(8'h11 * (i + 1));
      exp_q.push_back(v);
      cyc(0, 1, 8'h00);
      check("t2_dcount", int'(bus.count), 7 - i);
    end
    cyc(0, 0, 8'h00);
    check("t2_empty", int'(bus.empty), 1);
    check("t2_valid_off", int'(bus.out_valid), 0);
    check("t2_out_hold", int'(bus.out), 8'h88);

    // 3: overflow on write while full
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(i + 1));
    cyc(1, 0, 8'h99);
    check("t3_ovf", int'(bus.overflow), 1);
    check("t3_count", int'(bus.count), 8);
    check("t3_full", int'(bus.full), 1);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'(i + 1));
      cyc(0, 1, 8'h00);
    end
    cyc(0, 0, 8'h00);
    cyc(0, 0, 8'h00);
    check("t3_empty", int'(bus.empty), 1);
    check("t3_ovf_sticky", int'(bus.overflow), 1);

    // 4: we & re while empty
    cyc(1, 1, 8'hA5);
    check("t4_count", int'(bus.count), 1);
    check("t4_unf", int'(bus.underflow), 1);
    check("t4_valid", int'(bus.out_valid), 0);
    exp_q.push_back(8'hA5);
    cyc(0, 1, 8'h00);
    check("t4_valid_on", int'(bus.out_valid), 1);
    check("t4_out", int'(bus.out), 8'hA5);
    cyc(0, 0, 8'h00);
    check("t4_empty", int'(bus.empty), 1);

    // 5: steady count 3 across pointer wrap
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(i));
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'(i));
      cyc(1, 1, 8'(i + 3));
      check("t5_count", int'(bus.count), 3);
    end
    for (int i = 20; i < 23; i++) begin
      exp_q.push_back(8'(i));
      cyc(0, 1, 8'h00);
    end
    cyc(0, 0, 8'h00);
    check("t5_empty", int'(bus.empty), 1);

    // 6: reset mid-stream with we=re=1
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'(8'h50 + i));
    check("t6_pre", int'(bus.count), 5);
    rst    = 1'b1;
    bus.we = 1'b1;
    bus.re = 1'b1;
    bus.in = 8'hEE;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bus.we = 1'b0;
    bus.re = 1'b0;
    check("t6_count", int'(bus.count), 0);
    check("t6_empty", int'(bus.empty), 1);
    check("t6_ovf", int'(bus.overflow), 0);
    check("t6_unf", int'(bus.underflow), 0);
    check("t6_valid", int'(bus.out_valid), 0);
    check("t6_out", int'(bus.out), 0);
    cyc(0, 1, 8'h00);
    check("t6_unf_set", int'(bus.underflow), 1);
    check("t6_novalid", int'(bus.out_valid), 0);
    cyc(1, 0, 8'hC1);
    exp_q.push_back(8'hC1);
    cyc(0, 1, 8'h00);
    cyc(0, 0, 8'h00);
    check("t6_empty2", int'(bus.empty), 1);

    cyc(0, 0, 8'h00);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
